// File: rtl/branch_predictor.sv
// Tagged BTB with per-entry 2-bit saturating direction counters, looked up from IF and trained from WB.
// Optional gshare counter indexing is enabled with `define BP_GSHARE_EN.
module branch_predictor #(
    parameter int IDX_W    = 10,
    parameter int TAG_W    = 8,
    parameter int CTR_INIT = 1,
    parameter int HIST_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pred_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic              upd_branch,
    input  logic              upd_taken,
    input  logic [31:0]       upd_pc,
    input  logic [31:0]       upd_target,
    input  logic [HIST_W-1:0] upd_hist
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr        [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [HIST_W-1:0]  ghr;

    logic [IDX_W-1:0] p_idx, p_cidx, u_idx, u_cidx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    // Lookup-stage registers; the pred_* outputs are decoded from these.
    logic              lk_ok;
    logic              lk_valid;
    logic              lk_ctr_hi;
    logic [31:0]       lk_pc;
    logic [HIST_W-1:0] lk_hist;
    logic [TAG_W-1:0]  lk_tag;
    logic [31:0]       lk_target;

    assign p_idx = pred_pc[2 +: IDX_W];
    assign u_idx = upd_pc[2 +: IDX_W];
    assign u_tag = upd_pc[2+IDX_W +: TAG_W];
    assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);

`ifdef BP_GSHARE_EN
    assign p_cidx = p_idx ^ IDX_W'(ghr);
    assign u_cidx = u_idx ^ IDX_W'(upd_hist);

    // History advances only on retired branches, so it never needs repair.
    always_ff @(posedge clk) begin
        if (rst)
            ghr <= '0;
        else if (upd_valid && upd_branch)
            ghr <= {ghr[HIST_W-2:0], upd_taken};
    end
`else
    assign p_cidx = p_idx;
    assign u_cidx = u_idx;
    assign ghr    = '0;
`endif

    // Upper PC bits and (in the plain build) upd_hist carry no information here.
    logic unused_ok;
    assign unused_ok = ^{upd_pc, upd_hist};

    // NOTE: all state uses non-blocking assignments so every reader sees pre-edge values,
    // which is exactly the read-before-write behaviour a same-cycle lookup needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= 2'(CTR_INIT);
        end else if (upd_valid) begin
            if (upd_branch) begin
                if (u_hit) begin
                    if (upd_taken && ctr[u_cidx] != 2'd3)
                        ctr[u_cidx] <= ctr[u_cidx] + 2'd1;
                    else if (!upd_taken && ctr[u_cidx] != 2'd0)
                        ctr[u_cidx] <= ctr[u_cidx] - 2'd1;
                end else if (upd_taken) begin
                    valid[u_idx] <= 1'b1;
                    ctr[u_cidx]  <= 2'd2;
                end
            end else if (u_hit) begin
                valid[u_idx] <= 1'b0;
            end
        end
    end

    // NOTE: tag/target storage is deliberately not reset; the reset valid[] bits make
    // stale contents unobservable, and this keeps the arrays mappable onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_branch && upd_taken) begin
            tag_mem[u_idx]    <= u_tag;
            target_mem[u_idx] <= upd_target;
        end
        lk_tag    <= tag_mem[p_idx];
        lk_target <= target_mem[p_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_ok     <= 1'b0;
            lk_valid  <= 1'b0;
            lk_ctr_hi <= 1'b0;
            lk_pc     <= '0;
            lk_hist   <= '0;
        end else begin
            lk_ok     <= 1'b1;
            lk_valid  <= valid[p_idx];
            lk_ctr_hi <= ctr[p_cidx][1];
            lk_pc     <= pred_pc;
            lk_hist   <= ghr;
        end
    end

    assign pred_hit    = lk_valid && (lk_tag == lk_pc[2+IDX_W +: TAG_W]);
    assign pred_taken  = pred_hit && lk_ctr_hi;
    assign pred_target = !lk_ok     ? 32'd0 :
                         pred_taken ? lk_target : lk_pc + 32'd4;
    assign pred_hist   = lk_hist;

endmodule
